// File: rtl/fir_coeff_sequencer_if.sv
// Coefficient stream (cf_*) and coefficient-memory write port (coef_*) of the FIR coefficient sequencer.
// master = sequencer side, slave = coefficient source / memory side.
interface fir_coeff_sequencer_if #(
    parameter int NTAPS  = 64,
    parameter int COEF_W = 16
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    logic              cf_valid;
    logic [COEF_W-1:0] cf_data;
    logic              cf_ready;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_wdata;

    modport master (
        input  cf_valid, cf_data,
        output cf_ready, coef_we, coef_addr, coef_wdata
    );

    modport slave (
        output cf_valid, cf_data,
        input  cf_ready, coef_we, coef_addr, coef_wdata
    );
endinterface

// File: rtl/fir_coeff_sequencer.sv
// FIR coefficient reload sequencer: FLUSH -> RUN, with LOAD entered on load_start; all outputs registered.
// Coefficient writes appear one cycle after acceptance; cf_ready is high for every LOAD cycle, gaps in cf_valid stall the load.
module fir_coeff_sequencer #(
    parameter int NTAPS        = 64,
    parameter int COEF_W       = 16,
    parameter int FLUSH_CYCLES = 72,
    parameter int FRAME_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  abort,
    fir_coeff_sequencer_if.master bus,
    output logic                  fir_clr,
    output logic                  out_valid,
    output logic                  sof,
    output logic                  busy,
    output logic                  load_err
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_LOAD} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
    logic [AW-1:0]     word_cnt_q, word_cnt_d;
    logic              cf_ready_q, cf_ready_d;
    logic              coef_we_q, coef_we_d;
    logic [AW-1:0]     coef_addr_q, coef_addr_d;
    logic [COEF_W-1:0] coef_wdata_q, coef_wdata_d;
    logic              fir_clr_q, fir_clr_d;
    logic              out_valid_q, out_valid_d;
    logic              sof_q, sof_d;
    logic              busy_q, busy_d;
    logic              load_err_q, load_err_d;
    logic              accept;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        word_cnt_d   = word_cnt_q;
        coef_we_d    = 1'b0;
        coef_addr_d  = coef_addr_q;
        coef_wdata_d = coef_wdata_q;
        load_err_d   = 1'b0;

        accept = bus.cf_valid && cf_ready_q;
        if (accept) begin
            coef_we_d    = 1'b1;
            coef_addr_d  = word_cnt_q;
            coef_wdata_d = bus.cf_data;
            word_cnt_d   = word_cnt_q + AW'(1);
        end

        case (state_q)
            ST_FLUSH: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                end else if (fir_clr_q) begin
                    // FLUSH with fir_clr still high only happens in the cycle reset is released;
                    // counting begins once the datapath clear has dropped.
                    flush_cnt_d = '0;
                end else if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    samp_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                end else if (samp_cnt_q == SW'(FRAME_LEN - 1)) begin
                    samp_cnt_d = '0;
                end else begin
                    samp_cnt_d = samp_cnt_q + SW'(1);
                end
            end
            ST_LOAD: begin
                // Abort wins over a simultaneous load_start; a word accepted alongside it is still written.
                if (abort) begin
                    load_err_d  = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (accept && (word_cnt_q == AW'(NTAPS - 1))) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (load_start) begin
                    load_err_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_FLUSH;
                flush_cnt_d = '0;
            end
        endcase

        cf_ready_d  = (state_d == ST_LOAD);
        fir_clr_d   = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_RUN);
        sof_d       = (state_d == ST_RUN) && (samp_cnt_d == '0);
        busy_d      = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            samp_cnt_q   <= '0;
            word_cnt_q   <= '0;
            cf_ready_q   <= 1'b0;
            coef_we_q    <= 1'b0;
            coef_addr_q  <= '0;
            coef_wdata_q <= '0;
            fir_clr_q    <= 1'b1;
            out_valid_q  <= 1'b0;
            sof_q        <= 1'b0;
            busy_q       <= 1'b1;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            word_cnt_q   <= word_cnt_d;
            cf_ready_q   <= cf_ready_d;
            coef_we_q    <= coef_we_d;
            coef_addr_q  <= coef_addr_d;
            coef_wdata_q <= coef_wdata_d;
            fir_clr_q    <= fir_clr_d;
            out_valid_q  <= out_valid_d;
            sof_q        <= sof_d;
            busy_q       <= busy_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.cf_ready   = cf_ready_q;
    assign bus.coef_we    = coef_we_q;
    assign bus.coef_addr  = coef_addr_q;
    assign bus.coef_wdata = coef_wdata_q;
    assign fir_clr        = fir_clr_q;
    assign out_valid      = out_valid_q;
    assign sof            = sof_q;
    assign busy           = busy_q;
    assign load_err       = load_err_q;
endmodule
